// File: rtl/aes_shift_rows_pipe.sv
// Registered ShiftRows / InvShiftRows stage for Rijndael (Nb = 4, 6, 8) with a
// 2-entry output/skid buffer. Direction is chosen per block by in_inv.
//
//   state   | meaning
//   EMPTY   | output register empty, out_valid low
//   ONE     | output register holds a block, skid empty
//   FULL    | output and skid registers both hold blocks, in_ready low
module aes_shift_rows_pipe #(
  parameter int NB    = 4,
  parameter int TAG_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [32*NB-1:0]  in_data,
  input  logic              in_inv,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int W = 32 * NB;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shift_rows_pipe: TAG_W must be at least 1");
  end

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  state_e             state_q, state_d;
  logic               in_ready_q;
  logic [W-1:0]       or_data_q, or_data_d, sk_data_q, sk_data_d;
  logic [TAG_W-1:0]   or_tag_q, or_tag_d, sk_tag_q, sk_tag_d;
  logic [W-1:0]       shifted;
  logic               acc, rel;

  function automatic int row_off(input int r);
    if (r == 0)              return 0;
    else if (NB == 8 && r >= 2) return r + 1;
    else                     return r;
  endfunction

  // Both directions are built with constant byte selects; in_inv only steers a mux.
  always_comb begin
    shifted = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[W-1-8*(4*c+r) -: 8] = in_inv
          ? in_data[W-1-8*(4*((c + NB - row_off(r)) % NB)+r) -: 8]
          : in_data[W-1-8*(4*((c + row_off(r)) % NB)+r) -: 8];
      end
    end
  end

  assign acc = in_valid && in_ready_q;
  assign rel = (state_q != S_EMPTY) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_EMPTY;
      in_ready_q <= 1'b0;
      or_data_q  <= '0;
      or_tag_q   <= '0;
      sk_data_q  <= '0;
      sk_tag_q   <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != S_FULL);
      or_data_q  <= or_data_d;
      or_tag_q   <= or_tag_d;
      sk_data_q  <= sk_data_d;
      sk_tag_q   <= sk_tag_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    or_data_d = or_data_q;
    or_tag_d  = or_tag_q;
    sk_data_d = sk_data_q;
    sk_tag_d  = sk_tag_q;
    unique case (state_q)
      S_EMPTY: begin
        if (acc) begin
          or_data_d = shifted;
          or_tag_d  = in_tag;
          state_d   = S_ONE;
        end
      end
      S_ONE: begin
        if (acc && rel) begin
          or_data_d = shifted;
          or_tag_d  = in_tag;
        end else if (acc) begin
          sk_data_d = shifted;
          sk_tag_d  = in_tag;
          state_d   = S_FULL;
        end else if (rel) begin
          state_d   = S_EMPTY;
        end
      end
      S_FULL: begin
        if (rel) begin
          or_data_d = sk_data_q;
          or_tag_d  = sk_tag_q;
          state_d   = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state_q != S_EMPTY);
    in_ready  = in_ready_q;
    out_data  = or_data_q;
    out_tag   = or_tag_q;
  end

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Directed and randomised checks of aes_shift_rows_pipe at NB = 4, 8 and 6.
module tb_aes_shift_rows_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  localparam logic [127:0] A_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] A_FWD = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [255:0] B_IN  =
    256'h00010203_04050607_08090a0b_0c0d0e0f_10111213_14151617_18191a1b_1c1d1e1f;
  localparam logic [255:0] B_FWD =
    256'h00050e13_04091217_080d161b_0c111a1f_10151e03_14190207_181d060b_1c010a0f;

  logic a_in_valid = 0, a_in_ready, a_in_inv = 0, a_out_valid, a_out_ready = 1;
  logic [127:0] a_in_data = '0, a_out_data;
  logic [3:0] a_in_tag = '0, a_out_tag;

  logic b_in_valid = 0, b_in_ready, b_in_inv = 0, b_out_valid, b_out_ready = 1;
  logic [255:0] b_in_data = '0, b_out_data;
  logic [3:0] b_in_tag = '0, b_out_tag;

  logic c_in_valid = 0, c_in_ready, c_in_inv = 0, c_out_valid, c_out_ready = 1;
  logic [191:0] c_in_data = '0, c_out_data;
  logic [3:0] c_in_tag = '0, c_out_tag;

  aes_shift_rows_pipe #(.NB(4), .TAG_W(4)) u_nb4 (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_inv(a_in_inv), .in_tag(a_in_tag),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_tag(a_out_tag));

  aes_shift_rows_pipe #(.NB(8), .TAG_W(4)) u_nb8 (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_inv(b_in_inv), .in_tag(b_in_tag),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_tag(b_out_tag));

  aes_shift_rows_pipe #(.NB(6), .TAG_W(4)) u_nb6 (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_inv(c_in_inv), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .out_tag(c_out_tag));

  // Reference for NB=6 (offsets 0,1,2,3), working on an explicit byte matrix.
  function automatic logic [191:0] ref6(input logic [191:0] d, input logic inv);
    logic [7:0] m [4][6];
    logic [191:0] res;
    int sc;
    res = '0;
    for (int c = 0; c < 6; c++)
      for (int r = 0; r < 4; r++)
        m[r][c] = d[191-8*(4*c+r) -: 8];
    for (int c = 0; c < 6; c++)
      for (int r = 0; r < 4; r++) begin
        sc = inv ? (c + 6 - r) % 6 : (c + r) % 6;
        res[191-8*(4*c+r) -: 8] = m[r][sc];
      end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got valid=%b ready=%b exp 0 0", a_out_valid, a_in_ready);
    end
    checks++;
    if (a_out_data !== '0 || a_out_tag !== '0) begin
      failures++;
      $display("FAIL reset_data got %h/%h exp 0/0", a_out_data, a_out_tag);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1 || c_in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready got %b%b%b exp 111", a_in_ready, b_in_ready, c_in_ready);
    end
  endtask

  task automatic test_fwd_nb4();
    a_in_valid = 1; a_in_data = A_IN; a_in_inv = 0; a_in_tag = 4'h5; a_out_ready = 1;
    tick();
    a_in_valid = 0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_data !== A_FWD || a_out_tag !== 4'h5) begin
      failures++;
      $display("FAIL fwd_nb4 got v=%b %h t=%h exp v=1 %h t=5", a_out_valid, a_out_data, a_out_tag, A_FWD);
    end
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL fwd_nb4_drain got valid=%b exp 0", a_out_valid);
    end
  endtask

  task automatic test_alternate_nb4();
    logic [127:0] exp;
    for (int i = 0; i < 6; i++) begin
      a_in_valid = 1;
      a_in_inv = i[0];
      a_in_data = a_in_inv ? A_FWD : A_IN;
      a_in_tag = 4'(i + 8);
      exp = a_in_inv ? A_IN : A_FWD;
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_data !== exp || a_out_tag !== 4'(i + 8)) begin
        failures++;
        $display("FAIL alt_nb4 beat %0d got v=%b %h t=%h exp %h t=%h", i, a_out_valid,
                 a_out_data, a_out_tag, exp, 4'(i + 8));
      end
    end
    a_in_valid = 0;
    tick();
  endtask

  task automatic test_nb8();
    b_in_valid = 1; b_in_data = B_IN; b_in_inv = 0; b_in_tag = 4'h3;
    tick();
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== B_FWD || b_out_tag !== 4'h3) begin
      failures++;
      $display("FAIL fwd_nb8 got %h exp %h", b_out_data, B_FWD);
    end
    checks++;
    if (b_out_data[255:224] !== 32'h00050e13 || b_out_data[31:0] !== 32'h1c010a0f) begin
      failures++;
      $display("FAIL fwd_nb8_cols got c0=%h c7=%h exp 00050e13 1c010a0f",
               b_out_data[255:224], b_out_data[31:0]);
    end
    b_in_data = B_FWD; b_in_inv = 1; b_in_tag = 4'h4;
    tick();
    b_in_valid = 0;
    checks++;
    if (b_out_valid !== 1'b1 || b_out_data !== B_IN || b_out_tag !== 4'h4) begin
      failures++;
      $display("FAIL inv_nb8 got %h exp %h", b_out_data, B_IN);
    end
    tick();
  endtask

  task automatic test_backpressure();
    int sent = 0, rcvd = 0, cyc = 0, acc_at_drop = -1, bubbles = 0;
    a_in_data = A_IN; a_in_inv = 0;
    while (rcvd < 6 && cyc < 40) begin
      a_out_ready = (cyc >= 3);
      a_in_valid = (sent < 6);
      a_in_tag = 4'(sent + 1);
      if (!a_in_ready && acc_at_drop < 0) acc_at_drop = sent;
      if (a_out_valid && a_out_ready) begin
        checks++;
        if (a_out_tag !== 4'(rcvd + 1) || a_out_data !== A_FWD) begin
          failures++;
          $display("FAIL bp_order got tag=%h exp tag=%h", a_out_tag, 4'(rcvd + 1));
        end
        rcvd++;
      end else if (a_out_ready && rcvd > 0) begin
        bubbles++;
      end
      if (a_in_valid && a_in_ready) sent++;
      tick();
      cyc++;
    end
    a_in_valid = 0;
    a_out_ready = 1;
    checks++;
    if (rcvd != 6 || sent != 6) begin
      failures++;
      $display("FAIL bp_count got sent=%0d rcvd=%0d exp 6 6", sent, rcvd);
    end
    checks++;
    if (acc_at_drop != 2) begin
      failures++;
      $display("FAIL bp_ready_drop got accepts=%0d exp 2", acc_at_drop);
    end
    checks++;
    if (bubbles != 0) begin
      failures++;
      $display("FAIL bp_throughput got bubbles=%0d exp 0", bubbles);
    end
    tick();
  endtask

  task automatic test_reset_full();
    a_out_ready = 0; a_in_data = A_IN; a_in_inv = 0;
    a_in_valid = 1; a_in_tag = 4'h7;
    tick();
    a_in_tag = 4'h8;
    tick();
    a_in_valid = 0;
    checks++;
    if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rf_full got ready=%b valid=%b exp 0 1", a_in_ready, a_out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b0 || a_out_data !== '0 || a_out_tag !== '0) begin
      failures++;
      $display("FAIL rf_async got v=%b r=%b d=%h t=%h exp 0 0 0 0", a_out_valid, a_in_ready,
               a_out_data, a_out_tag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    a_out_ready = 1;
    tick();
    checks++;
    if (a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rf_release got ready=%b valid=%b exp 1 0", a_in_ready, a_out_valid);
    end
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rf_no_ghost got valid=%b exp 0", a_out_valid);
    end
    a_in_valid = 1; a_in_tag = 4'h9;
    tick();
    a_in_valid = 0;
    checks++;
    if (a_out_valid !== 1'b1 || a_out_tag !== 4'h9 || a_out_data !== A_FWD) begin
      failures++;
      $display("FAIL rf_new got v=%b t=%h d=%h exp 1 9 %h", a_out_valid, a_out_tag, a_out_data, A_FWD);
    end
    tick();
    checks++;
    if (a_out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rf_alone got valid=%b exp 0", a_out_valid);
    end
  endtask

  task automatic test_random_nb6();
    localparam int N = 10000;
    logic [191:0] exp_d[$];
    logic [3:0]   exp_t[$];
    logic [191:0] prev_data = '0, ed;
    logic [3:0]   et;
    logic prev_stall = 0, took;
    int beats_in = 0, beats_out = 0, cyc = 0;
    c_in_valid = 0;
    while (beats_out < N && cyc < 60000) begin
      if (!c_in_valid && beats_in < N && $urandom_range(0, 3) != 0) begin
        c_in_valid = 1;
        c_in_data = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        c_in_inv = 1'($urandom_range(0, 1));
        c_in_tag = 4'($urandom_range(0, 15));
      end
      c_out_ready = ($urandom_range(0, 3) != 0);
      if (prev_stall) begin
        checks++;
        if (c_out_valid !== 1'b1 || c_out_data !== prev_data) begin
          failures++;
          $display("FAIL rnd_stable got v=%b %h exp 1 %h", c_out_valid, c_out_data, prev_data);
        end
      end
      if (c_out_valid && c_out_ready) begin
        checks++;
        if (exp_d.size() == 0) begin
          failures++;
          $display("FAIL rnd_extra got tag=%h exp no output", c_out_tag);
        end else begin
          ed = exp_d.pop_front();
          et = exp_t.pop_front();
          if (c_out_data !== ed || c_out_tag !== et) begin
            failures++;
            $display("FAIL rnd_data beat %0d got %h t=%h exp %h t=%h", beats_out, c_out_data,
                     c_out_tag, ed, et);
          end
        end
        beats_out++;
      end
      prev_stall = c_out_valid && !c_out_ready;
      prev_data = c_out_data;
      took = c_in_valid && c_in_ready;
      if (took) begin
        exp_d.push_back(ref6(c_in_data, c_in_inv));
        exp_t.push_back(c_in_tag);
        beats_in++;
      end
      tick();
      cyc++;
      if (took) c_in_valid = 0;
    end
    c_in_valid = 0;
    c_out_ready = 1;
    checks++;
    if (beats_out != N || exp_d.size() != 0) begin
      failures++;
      $display("FAIL rnd_count got out=%0d pending=%0d exp %0d 0", beats_out, exp_d.size(), N);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_nb4();
    test_alternate_nb4();
    test_nb8();
    test_backpressure();
    test_reset_full();
    test_random_nb6();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
